// File: rtl/add_sub_accum.sv
// Block accumulator: sums COUNT unsigned samples from the add_sub datapath and
// presents each total on a valid/ready output. The accumulator is wide enough that it cannot overflow.
//
// state | meaning
// ACCUM | accepting samples into acc, in_ready=1
// HOLD  | presenting completed sum, out_valid=1
module add_sub_accum #(
  parameter int WIDTH = 32,
  parameter int COUNT = 16,
  localparam int ACC_WIDTH = WIDTH + $clog2(COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_q, out_d;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] sum;

  assign in_ext = ACC_WIDTH'(in_data);
  // The first sample of a block overwrites acc, so a stale acc left by clear never leaks.
  assign sum    = (count_q == '0) ? in_ext : acc_q + in_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      count_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          count_d = '0;
        end else if (in_valid) begin
          if (count_q == LAST) begin
            out_d   = sum;
            count_d = '0;
            state_d = HOLD;
          end else begin
            acc_d   = sum;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_q;

endmodule

// File: tb/tb_add_sub_accum.sv
// Directed and scoreboarded bench for add_sub_accum; instance a is WIDTH=8/COUNT=4,
// instance b is WIDTH=32/COUNT=1.
module tb_add_sub_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data_a;
  logic        in_valid_a, clear_a, out_ready_a;
  logic        in_ready_a, out_valid_a;
  logic [9:0]  out_data_a;
  logic [31:0] in_data_b;
  logic        in_valid_b, clear_b, out_ready_b;
  logic        in_ready_b, out_valid_b;
  logic [31:0] out_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  add_sub_accum #(.WIDTH(8), .COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .clear(clear_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  add_sub_accum #(.WIDTH(32), .COUNT(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .clear(clear_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  // Drives one sample across one rising edge; inputs change only at negedges.
  task automatic send_a(input logic [7:0] d);
    in_data_a  = d;
    in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_data_a = 8'd77; in_valid_a = 1'b1; clear_a = 1'b0; out_ready_a = 1'b0;
    in_data_b = 32'd77; in_valid_b = 1'b1; clear_b = 1'b0; out_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a got %0b exp 0", out_valid_a); end
    n_checks++;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a got %0b exp 1", in_ready_a); end
    n_checks++;
    if (out_data_a !== 10'd0) begin n_fail++; $display("FAIL reset_out_data_a got %0d exp 0", out_data_a); end
    n_checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1 || out_data_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_b got valid=%0b ready=%0b data=%0h exp 0/1/0", out_valid_b, in_ready_b, out_data_b);
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
        n_fail++; $display("FAIL basic_accum_%0d got ready=%0b valid=%0b exp 1/0", i, in_ready_a, out_valid_a);
      end
      send_a(8'(i));
    end
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd10 || in_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum got valid=%0b data=%0d ready=%0b exp 1/10/0", out_valid_a, out_data_a, in_ready_a);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL basic_release got valid=%0b ready=%0b exp 0/1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_max();
    out_ready_a = 1'b1;
    repeat (4) send_a(8'd255);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd1020) begin
      n_fail++; $display("FAIL max_sum got valid=%0b data=%0d exp 1/1020", out_valid_a, out_data_a);
    end
    @(negedge clk);
    send_a(8'd0); send_a(8'd0); send_a(8'd0); send_a(8'd1);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd1) begin
      n_fail++; $display("FAIL max_restart got valid=%0b data=%0d exp 1/1", out_valid_a, out_data_a);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    repeat (4) send_a(8'd5);
    in_data_a = 8'd100; in_valid_a = 1'b1;
    for (int c = 0; c < 7; c++) begin
      n_checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== 10'd20 || in_ready_a !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d got valid=%0b data=%0d ready=%0b exp 1/20/0", c, out_valid_a, out_data_a, in_ready_a);
      end
      if (c < 6) @(negedge clk);
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got valid=%0b ready=%0b exp 0/1", out_valid_a, in_ready_a);
    end
    repeat (4) send_a(8'd1);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd4) begin
      n_fail++; $display("FAIL bp_no_accept got valid=%0b data=%0d exp 1/4", out_valid_a, out_data_a);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    out_ready_a = 1'b1;
    send_a(8'd9); send_a(8'd9);
    clear_a = 1'b1; in_data_a = 8'd9; in_valid_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0; in_valid_a = 1'b0;
    repeat (4) send_a(8'd1);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd4) begin
      n_fail++; $display("FAIL clear_sum got valid=%0b data=%0d exp 1/4", out_valid_a, out_data_a);
    end
    @(negedge clk);
    out_ready_a = 1'b0;
    repeat (4) send_a(8'd2);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd8) begin
      n_fail++; $display("FAIL clear_in_hold got valid=%0b data=%0d exp 1/8", out_valid_a, out_data_a);
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL clear_hold_release got valid=%0b exp 0", out_valid_a); end
  endtask

  task automatic test_reset_mid();
    out_ready_a = 1'b1;
    repeat (3) send_a(8'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 10'd0) begin
      n_fail++; $display("FAIL reset_mid got valid=%0b ready=%0b data=%0d exp 0/1/0", out_valid_a, in_ready_a, out_data_a);
    end
    repeat (4) send_a(8'd2);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 10'd8) begin
      n_fail++; $display("FAIL reset_mid_sum got valid=%0b data=%0d exp 1/8", out_valid_a, out_data_a);
    end
    @(negedge clk);
  endtask

  task automatic test_count1();
    logic [31:0] last;
    int          n_out;
    out_ready_b = 1'b1;
    in_data_b = 32'hFFFF_FFFF; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    n_checks++;
    if (out_valid_b !== 1'b1 || out_data_b !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL count1_max got valid=%0b data=%0h exp 1/ffffffff", out_valid_b, out_data_b);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0) begin
      n_fail++; $display("FAIL count1_release got ready=%0b valid=%0b exp 1/0", in_ready_b, out_valid_b);
    end
    // Continuous in_valid: accepts land on even cycles, giving one result every 2 cycles.
    n_out = 0;
    last  = '0;
    in_valid_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data_b = 32'hA000_0000 + 32'(i);
      if (i % 2 == 0) last = in_data_b;
      @(negedge clk);
      n_checks++;
      if (out_valid_b !== (i % 2 == 0)) begin
        n_fail++; $display("FAIL count1_rate_%0d got valid=%0b exp %0b", i, out_valid_b, (i % 2 == 0));
      end
      if (out_valid_b === 1'b1) begin
        n_out++;
        n_checks++;
        if (out_data_b !== last) begin n_fail++; $display("FAIL count1_data_%0d got %0h exp %0h", i, out_data_b, last); end
      end
    end
    in_valid_b = 1'b0;
    n_checks++;
    if (n_out != 5) begin n_fail++; $display("FAIL count1_results got %0d exp 5", n_out); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          m_hold = 1'b0;
    int          m_cnt  = 0;
    int          m_acc  = 0;
    int          m_out  = 0;
    int          sums   = 0;
    int          cycles = 0;
    logic [7:0]  d;
    while (sums < 1000 && cycles < 40000) begin
      n_checks++;
      if (out_valid_a !== m_hold || in_ready_a !== !m_hold || (m_hold && out_data_a !== 10'(m_out))) begin
        n_fail++;
        $display("FAIL random_cyc%0d got valid=%0b ready=%0b data=%0d exp valid=%0b data=%0d",
                 cycles, out_valid_a, in_ready_a, out_data_a, m_hold, m_out);
      end
      d = 8'($urandom_range(0, 255));
      in_data_a   = d;
      in_valid_a  = ($urandom_range(0, 9) < 7);
      out_ready_a = ($urandom_range(0, 9) < 6);
      if (!m_hold) begin
        if (in_valid_a) begin
          m_acc += int'(d);
          m_cnt++;
          if (m_cnt == 4) begin
            m_out  = m_acc;
            m_acc  = 0;
            m_cnt  = 0;
            m_hold = 1'b1;
          end
        end
      end else if (out_ready_a) begin
        m_hold = 1'b0;
        sums++;
      end
      @(negedge clk);
      cycles++;
    end
    in_valid_a = 1'b0;
    n_checks++;
    if (sums < 1000) begin n_fail++; $display("FAIL random_budget got %0d sums exp 1000", sums); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_count1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
